// File: rtl/armv8_pkg.sv
// Shared definitions for the LEGv8 decode stage.
// Contents:
//   - XZR register index
//   - opcode field constants for the supported instruction subset
//   - ALU operation encodings (alu_op_e)
//   - control bundle carried through ID/EX (ctrl_t) and its bubble value
package armv8_pkg;

    localparam logic [4:0] XZR = 5'd31;

    // Opcodes, compared against the top bits of the instruction word.
    localparam logic [10:0] OP_ADD  = 11'b10001011000;  // bits 31:21
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;   // bits 31:22
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;      // bits 31:24
    localparam logic [5:0]  OP_B    = 6'b000101;        // bits 31:26

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_ORR = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110
    } alu_op_e;

    typedef struct packed {
        alu_op_e alu_op;
        logic    alusrc;
        logic    memread;
        logic    memwrite;
        logic    memtoreg;
        logic    regwrite;
    } ctrl_t;

    // All-zero bundle: a bubble has AND as its (harmless) ALU op.
    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/register_file.sv
// 32 x XLEN architectural register file with XZR handling.
// Ports:
//   clock, reset          synchronous active-high reset clears every register
//   rd_addr1/rd_data1     read port 1 (combinational)
//   rd_addr2/rd_data2     read port 2 (combinational)
//   wr_en/wr_addr/wr_data write port, committed on the rising clock edge
// The highest index is the zero register: writes to it are dropped and
// reads of it return 0. A read of the address being written in the same
// cycle returns the incoming write data (write-through), so writeback and
// decode can share a cycle without a separate forwarding path.
module register_file #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [$clog2(NREGS)-1:0] rd_addr1,
    input  logic [$clog2(NREGS)-1:0] rd_addr2,
    output logic [XLEN-1:0]          rd_data1,
    output logic [XLEN-1:0]          rd_data2,
    input  logic                     wr_en,
    input  logic [$clog2(NREGS)-1:0] wr_addr,
    input  logic [XLEN-1:0]          wr_data
);

    localparam int AW = $clog2(NREGS);
    localparam logic [AW-1:0] ZR = AW'(NREGS - 1);

    logic [XLEN-1:0] regs [NREGS];

    // One storage register per writable index; the zero register has no
    // storage at all, which is what makes writes to it disappear.
    genvar gi;
    generate
        for (gi = 0; gi < NREGS - 1; gi++) begin : g_reg
            logic [XLEN-1:0] q_reg;
            always_ff @(posedge clock) begin
                if (reset) begin
                    q_reg <= '0;
                end else if (wr_en && wr_addr == AW'(gi)) begin
                    q_reg <= wr_data;
                end
            end
            assign regs[gi] = q_reg;
        end
    endgenerate

    assign regs[NREGS-1] = '0;

    always_comb begin
        rd_data1 = regs[rd_addr1];
        if (rd_addr1 == ZR) begin
            rd_data1 = '0;
        end else if (wr_en && wr_addr == rd_addr1) begin
            rd_data1 = wr_data;
        end
    end

    always_comb begin
        rd_data2 = regs[rd_addr2];
        if (rd_addr2 == ZR) begin
            rd_data2 = '0;
        end else if (wr_en && wr_addr == rd_addr2) begin
            rd_data2 = wr_data;
        end
    end

endmodule

// File: rtl/instruction_decode.sv
// ID stage of the 5-stage LEGv8 pipeline.
// Ports:
//   clock, reset                 synchronous active-high reset
//   instruction_in, pc_inc_in    IF/ID register contents
//   wb_regwrite/wb_rd/wb_data    writeback port into the register file
//   ex_memread/ex_regwrite/ex_rd, mem_regwrite/mem_rd
//                                destinations in flight, for hazard detection
//   pc_wren, if_id_wren          0 = hold fetch (stall)       [combinational]
//   if_id_flush, branch_taken    taken B/CBZ redirect        [combinational]
//   pc_branch                    branch target               [combinational]
//   id_ex_*                      ID/EX pipeline register      [registered]
// Stalls take priority over branch resolution: a CBZ whose operand is still
// in flight must not resolve on a stale value. Both a stall and a taken
// branch insert a bubble into ID/EX.
module instruction_decode
    import armv8_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int NREGS = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [31:0]     instruction_in,
    input  logic [XLEN-1:0] pc_inc_in,
    input  logic            wb_regwrite,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ex_memread,
    input  logic            ex_regwrite,
    input  logic [4:0]      ex_rd,
    input  logic            mem_regwrite,
    input  logic [4:0]      mem_rd,
    output logic            pc_wren,
    output logic            if_id_wren,
    output logic            if_id_flush,
    output logic            branch_taken,
    output logic [XLEN-1:0] pc_branch,
    output logic [XLEN-1:0] id_ex_read_data1,
    output logic [XLEN-1:0] id_ex_read_data2,
    output logic [XLEN-1:0] id_ex_imm,
    output logic [XLEN-1:0] id_ex_pc_inc,
    output logic [4:0]      id_ex_rn,
    output logic [4:0]      id_ex_rm,
    output logic [4:0]      id_ex_rd,
    output logic [3:0]      id_ex_alu_op,
    output logic            id_ex_alusrc,
    output logic            id_ex_memread,
    output logic            id_ex_memwrite,
    output logic            id_ex_memtoreg,
    output logic            id_ex_regwrite
);

    // ---------------------------------------------------------------
    // Field extraction and decode
    // ---------------------------------------------------------------
    logic [4:0] rn_field, rm_field, rd_field, rd2_addr;
    logic       is_r, is_addi, is_ldur, is_stur, is_cbz, is_b;
    logic       uses_rn, uses_r2;
    ctrl_t      ctrl_dec;
    logic [XLEN-1:0] imm_dec;

    assign rn_field = instruction_in[9:5];
    assign rm_field = instruction_in[20:16];
    assign rd_field = instruction_in[4:0];   // Rd, or Rt for STUR/CBZ

    always_comb begin
        ctrl_dec = CTRL_BUBBLE;
        imm_dec  = '0;
        is_r     = 1'b0;
        is_addi  = 1'b0;
        is_ldur  = 1'b0;
        is_stur  = 1'b0;
        is_cbz   = 1'b0;
        is_b     = 1'b0;

        case (instruction_in[31:21])
            OP_ADD: begin
                is_r = 1'b1;
                ctrl_dec.alu_op   = ALU_ADD;
                ctrl_dec.regwrite = 1'b1;
            end
            OP_SUB: begin
                is_r = 1'b1;
                ctrl_dec.alu_op   = ALU_SUB;
                ctrl_dec.regwrite = 1'b1;
            end
            OP_AND: begin
                is_r = 1'b1;
                ctrl_dec.alu_op   = ALU_AND;
                ctrl_dec.regwrite = 1'b1;
            end
            OP_ORR: begin
                is_r = 1'b1;
                ctrl_dec.alu_op   = ALU_ORR;
                ctrl_dec.regwrite = 1'b1;
            end
            OP_LDUR: begin
                is_ldur = 1'b1;
                ctrl_dec.alu_op   = ALU_ADD;
                ctrl_dec.alusrc   = 1'b1;
                ctrl_dec.memread  = 1'b1;
                ctrl_dec.memtoreg = 1'b1;
                ctrl_dec.regwrite = 1'b1;
                imm_dec = {{(XLEN-9){instruction_in[20]}}, instruction_in[20:12]};
            end
            OP_STUR: begin
                is_stur = 1'b1;
                ctrl_dec.alu_op   = ALU_ADD;
                ctrl_dec.alusrc   = 1'b1;
                ctrl_dec.memwrite = 1'b1;
                imm_dec = {{(XLEN-9){instruction_in[20]}}, instruction_in[20:12]};
            end
            default: ;
        endcase

        if (instruction_in[31:22] == OP_ADDI) begin
            is_addi = 1'b1;
            ctrl_dec.alu_op   = ALU_ADD;
            ctrl_dec.alusrc   = 1'b1;
            ctrl_dec.regwrite = 1'b1;
            imm_dec = {{(XLEN-12){1'b0}}, instruction_in[21:10]};
        end
        // CBZ and B carry no EX/MEM/WB work, so their bundle stays a bubble.
        if (instruction_in[31:24] == OP_CBZ) is_cbz = 1'b1;
        if (instruction_in[31:26] == OP_B)   is_b   = 1'b1;
    end

    // Only registers an instruction really consumes may trigger a stall;
    // ADDI/LDUR bits 20:16 are immediate bits, not a register index.
    assign uses_rn  = is_r | is_addi | is_ldur | is_stur;
    assign uses_r2  = is_r | is_stur | is_cbz;
    assign rd2_addr = (is_stur | is_cbz) ? rd_field : rm_field;

    // ---------------------------------------------------------------
    // Register file
    // ---------------------------------------------------------------
    logic [XLEN-1:0] rd_data1, rd_data2;

    register_file #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_register_file (
        .clock    (clock),
        .reset    (reset),
        .rd_addr1 (rn_field),
        .rd_addr2 (rd2_addr),
        .rd_data1 (rd_data1),
        .rd_data2 (rd_data2),
        .wr_en    (wb_regwrite),
        .wr_addr  (wb_rd),
        .wr_data  (wb_data)
    );

    // ---------------------------------------------------------------
    // Hazards and branch resolution
    // ---------------------------------------------------------------
    logic load_use, cbz_wait, stall, taken, insert_bubble;
    logic [XLEN-1:0] branch_off;

    assign load_use = ex_memread && (ex_rd != XZR) &&
                      ((uses_rn && ex_rd == rn_field) || (uses_r2 && ex_rd == rd2_addr));

    // CBZ compares in ID, so it must wait for any producer still in EX or MEM.
    assign cbz_wait = is_cbz && (rd_field != XZR) &&
                      ((ex_regwrite && ex_rd == rd_field) || (mem_regwrite && mem_rd == rd_field));

    assign stall = load_use || cbz_wait;
    assign taken = !stall && (is_b || (is_cbz && rd_data2 == '0));
    assign insert_bubble = stall || taken;

    assign branch_off = is_b ? {{(XLEN-26){instruction_in[25]}}, instruction_in[25:0]}
                             : {{(XLEN-19){instruction_in[23]}}, instruction_in[23:5]};
    assign pc_branch  = (pc_inc_in - XLEN'(4)) + (branch_off << 2);

    always_comb begin
        pc_wren      = 1'b1;
        if_id_wren   = 1'b1;
        if_id_flush  = 1'b0;
        branch_taken = 1'b0;
        if (!reset) begin
            if (stall) begin
                pc_wren    = 1'b0;
                if_id_wren = 1'b0;
            end else if (taken) begin
                if_id_flush  = 1'b1;
                branch_taken = 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------
    // ID/EX pipeline register
    // ---------------------------------------------------------------
    ctrl_t           ctrl_reg, ctrl_next;
    logic [XLEN-1:0] data1_reg, data1_next, data2_reg, data2_next;
    logic [XLEN-1:0] imm_reg, imm_next, pc_inc_reg, pc_inc_next;
    logic [4:0]      rn_reg, rn_next, rm_reg, rm_next, rd_reg, rd_next;

    always_comb begin
        ctrl_next   = CTRL_BUBBLE;
        data1_next  = '0;
        data2_next  = '0;
        imm_next    = '0;
        pc_inc_next = '0;
        rn_next     = '0;
        rm_next     = '0;
        rd_next     = '0;
        if (!insert_bubble) begin
            ctrl_next   = ctrl_dec;
            data1_next  = rd_data1;
            data2_next  = rd_data2;
            imm_next    = imm_dec;
            pc_inc_next = pc_inc_in;
            rn_next     = rn_field;
            rm_next     = rd2_addr;
            rd_next     = rd_field;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ctrl_reg   <= CTRL_BUBBLE;
            data1_reg  <= '0;
            data2_reg  <= '0;
            imm_reg    <= '0;
            pc_inc_reg <= '0;
            rn_reg     <= '0;
            rm_reg     <= '0;
            rd_reg     <= '0;
        end else begin
            ctrl_reg   <= ctrl_next;
            data1_reg  <= data1_next;
            data2_reg  <= data2_next;
            imm_reg    <= imm_next;
            pc_inc_reg <= pc_inc_next;
            rn_reg     <= rn_next;
            rm_reg     <= rm_next;
            rd_reg     <= rd_next;
        end
    end

    assign id_ex_read_data1 = data1_reg;
    assign id_ex_read_data2 = data2_reg;
    assign id_ex_imm        = imm_reg;
    assign id_ex_pc_inc     = pc_inc_reg;
    assign id_ex_rn         = rn_reg;
    assign id_ex_rm         = rm_reg;
    assign id_ex_rd         = rd_reg;
    assign id_ex_alu_op     = ctrl_reg.alu_op;
    assign id_ex_alusrc     = ctrl_reg.alusrc;
    assign id_ex_memread    = ctrl_reg.memread;
    assign id_ex_memwrite   = ctrl_reg.memwrite;
    assign id_ex_memtoreg   = ctrl_reg.memtoreg;
    assign id_ex_regwrite   = ctrl_reg.regwrite;

endmodule

// File: tb/tb_instruction_decode.sv
// Directed testbench for instruction_decode.
// Stimulus is applied on the falling edge; combinational hazard/branch
// outputs are checked 1 ns later. The expected ID/EX contents for each
// cycle are queued, and a separate monitor pops and compares them 1 ns
// after the following rising edge.
module tb_instruction_decode;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] instruction_in;
    logic [63:0] pc_inc_in;
    logic        wb_regwrite;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        ex_memread, ex_regwrite, mem_regwrite;
    logic [4:0]  ex_rd, mem_rd;
    logic        pc_wren, if_id_wren, if_id_flush, branch_taken;
    logic [63:0] pc_branch;
    logic [63:0] id_ex_read_data1, id_ex_read_data2, id_ex_imm, id_ex_pc_inc;
    logic [4:0]  id_ex_rn, id_ex_rm, id_ex_rd;
    logic [3:0]  id_ex_alu_op;
    logic        id_ex_alusrc, id_ex_memread, id_ex_memwrite, id_ex_memtoreg, id_ex_regwrite;

    always #5 clock = ~clock;

    instruction_decode dut (
        .clock            (clock),
        .reset            (reset),
        .instruction_in   (instruction_in),
        .pc_inc_in        (pc_inc_in),
        .wb_regwrite      (wb_regwrite),
        .wb_rd            (wb_rd),
        .wb_data          (wb_data),
        .ex_memread       (ex_memread),
        .ex_regwrite      (ex_regwrite),
        .ex_rd            (ex_rd),
        .mem_regwrite     (mem_regwrite),
        .mem_rd           (mem_rd),
        .pc_wren          (pc_wren),
        .if_id_wren       (if_id_wren),
        .if_id_flush      (if_id_flush),
        .branch_taken     (branch_taken),
        .pc_branch        (pc_branch),
        .id_ex_read_data1 (id_ex_read_data1),
        .id_ex_read_data2 (id_ex_read_data2),
        .id_ex_imm        (id_ex_imm),
        .id_ex_pc_inc     (id_ex_pc_inc),
        .id_ex_rn         (id_ex_rn),
        .id_ex_rm         (id_ex_rm),
        .id_ex_rd         (id_ex_rd),
        .id_ex_alu_op     (id_ex_alu_op),
        .id_ex_alusrc     (id_ex_alusrc),
        .id_ex_memread    (id_ex_memread),
        .id_ex_memwrite   (id_ex_memwrite),
        .id_ex_memtoreg   (id_ex_memtoreg),
        .id_ex_regwrite   (id_ex_regwrite)
    );

    // mode 1: control bits only must be zero (bubble); mode 2: every field.
    typedef struct {
        int          mode;
        logic [63:0] rd1, rd2, imm, pc_inc;
        logic [4:0]  rn, rm, rd;
        logic [3:0]  alu;
        logic        alusrc, memread, memwrite, memtoreg, regwrite;
        bit          chk_imm;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    localparam logic [10:0] C_ADD  = 11'b10001011000;
    localparam logic [10:0] C_SUB  = 11'b11001011000;
    localparam logic [10:0] C_AND  = 11'b10001010000;
    localparam logic [10:0] C_ORR  = 11'b10101010000;
    localparam logic [10:0] C_LDUR = 11'b11111000010;
    localparam logic [10:0] C_STUR = 11'b11111000000;
    localparam logic [9:0]  C_ADDI = 10'b1001000100;
    localparam logic [7:0]  C_CBZ  = 8'b10110100;
    localparam logic [5:0]  C_B    = 6'b000101;

    function automatic logic [31:0] enc_r(logic [10:0] op, logic [4:0] rm, logic [4:0] rn, logic [4:0] rd);
        return {op, rm, 6'b0, rn, rd};
    endfunction
    function automatic logic [31:0] enc_addi(logic [11:0] imm, logic [4:0] rn, logic [4:0] rd);
        return {C_ADDI, imm, rn, rd};
    endfunction
    function automatic logic [31:0] enc_d(logic [10:0] op, logic [8:0] addr, logic [4:0] rn, logic [4:0] rt);
        return {op, addr, 2'b00, rn, rt};
    endfunction
    function automatic logic [31:0] enc_cbz(logic [18:0] imm, logic [4:0] rt);
        return {C_CBZ, imm, rt};
    endfunction
    function automatic logic [31:0] enc_b(logic [25:0] imm);
        return {C_B, imm};
    endfunction

    function automatic exp_t e_bubble();
        exp_t e = '{default: 0};
        e.mode = 1;
        return e;
    endfunction
    function automatic exp_t e_zero();
        exp_t e = '{default: 0};
        e.mode = 2;
        e.chk_imm = 1'b1;
        return e;
    endfunction
    function automatic exp_t e_full(logic [63:0] rd1, logic [63:0] rd2, logic [63:0] imm, bit chk_imm,
                                    logic [63:0] pc, logic [4:0] rn, logic [4:0] rm, logic [4:0] rd,
                                    logic [3:0] alu, logic s, logic mr, logic mw, logic mt, logic rw);
        exp_t e;
        e.mode = 2; e.rd1 = rd1; e.rd2 = rd2; e.imm = imm; e.chk_imm = chk_imm; e.pc_inc = pc;
        e.rn = rn; e.rm = rm; e.rd = rd; e.alu = alu;
        e.alusrc = s; e.memread = mr; e.memwrite = mw; e.memtoreg = mt; e.regwrite = rw;
        return e;
    endfunction

    task automatic cmp(string nm, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic comb(string nm, logic wren, logic flush, logic tk);
        #1;
        cmp({nm, ".pc_wren"},      64'(pc_wren),      64'(wren));
        cmp({nm, ".if_id_wren"},   64'(if_id_wren),   64'(wren));
        cmp({nm, ".if_id_flush"},  64'(if_id_flush),  64'(flush));
        cmp({nm, ".branch_taken"}, 64'(branch_taken), 64'(tk));
    endtask

    task automatic brt(string nm, logic [63:0] target);
        cmp({nm, ".pc_branch"}, pc_branch, target);
    endtask

    task automatic step(string nm, exp_t e);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clock);
    endtask

    // Monitor: one ID/EX transaction per rising edge.
    initial begin : monitor
        exp_t  e;
        string nm;
        int    n = 0;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                n++;
                cmp({nm, ".alu_op"},   64'(id_ex_alu_op),   64'(e.alu));
                cmp({nm, ".alusrc"},   64'(id_ex_alusrc),   64'(e.alusrc));
                cmp({nm, ".memread"},  64'(id_ex_memread),  64'(e.memread));
                cmp({nm, ".memwrite"}, 64'(id_ex_memwrite), 64'(e.memwrite));
                cmp({nm, ".memtoreg"}, 64'(id_ex_memtoreg), 64'(e.memtoreg));
                cmp({nm, ".regwrite"}, 64'(id_ex_regwrite), 64'(e.regwrite));
                if (e.mode == 2) begin
                    cmp({nm, ".read_data1"}, id_ex_read_data1, e.rd1);
                    cmp({nm, ".read_data2"}, id_ex_read_data2, e.rd2);
                    cmp({nm, ".pc_inc"},     id_ex_pc_inc,     e.pc_inc);
                    cmp({nm, ".rn"},         64'(id_ex_rn),    64'(e.rn));
                    cmp({nm, ".rm"},         64'(id_ex_rm),    64'(e.rm));
                    cmp({nm, ".rd"},         64'(id_ex_rd),    64'(e.rd));
                    if (e.chk_imm) cmp({nm, ".imm"}, id_ex_imm, e.imm);
                end
                $display("txn %0d %s alu=%b rw=%b d1=%h d2=%h", n, nm, id_ex_alu_op,
                         id_ex_regwrite, id_ex_read_data1, id_ex_read_data2);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin : stimulus
        reset = 1'b1; instruction_in = '0; pc_inc_in = '0;
        wb_regwrite = 1'b0; wb_rd = '0; wb_data = '0;
        ex_memread = 1'b0; ex_regwrite = 1'b0; ex_rd = '0;
        mem_regwrite = 1'b0; mem_rd = '0;

        comb("reset", 1, 0, 0);
        step("reset", e_zero());

        reset = 1'b0;
        comb("zero_instr", 1, 0, 0);
        step("zero_instr_bubble", e_bubble());

        wb_regwrite = 1; wb_rd = 1; wb_data = 64'd5;
        step("wb_x1", e_bubble());
        wb_rd = 2; wb_data = 64'd7;
        step("wb_x2", e_bubble());
        wb_regwrite = 0;

        // ADD X3,X1,X2
        pc_inc_in = 64'h40;
        instruction_in = enc_r(C_ADD, 2, 1, 3);
        if (instruction_in != 32'h8B020023) $display("note: encoder differs from 0x8B020023");
        comb("add", 1, 0, 0);
        step("add", e_full(5, 7, 0, 0, 64'h40, 1, 2, 3, 4'b0010, 0, 0, 0, 0, 1));

        // Load-use on Rn, then Rm, then a destination-only match (no stall)
        ex_memread = 1; ex_rd = 1;
        comb("loaduse_rn", 0, 0, 0);
        step("loaduse_rn_bubble", e_bubble());
        ex_rd = 2;
        comb("loaduse_rm", 0, 0, 0);
        step("loaduse_rm_bubble", e_bubble());
        ex_rd = 3;
        comb("loaduse_rd_only", 1, 0, 0);
        step("add_rd_only", e_full(5, 7, 0, 0, 64'h40, 1, 2, 3, 4'b0010, 0, 0, 0, 0, 1));
        ex_memread = 0; ex_rd = 1;
        comb("after_loaduse", 1, 0, 0);
        step("add_after_stall", e_full(5, 7, 0, 0, 64'h40, 1, 2, 3, 4'b0010, 0, 0, 0, 0, 1));
        ex_regwrite = 1;
        comb("ex_regwrite_no_load", 1, 0, 0);
        step("add_ex_regwrite", e_full(5, 7, 0, 0, 64'h40, 1, 2, 3, 4'b0010, 0, 0, 0, 0, 1));
        ex_regwrite = 0;

        // ADDI X6,X1,#0x123 -- bits 20:16 (=4) are immediate, no stall on them
        instruction_in = enc_addi(12'h123, 1, 6);
        ex_memread = 1; ex_rd = 4;
        comb("addi_no_stall", 1, 0, 0);
        step("addi", e_full(5, 0, 64'h123, 1, 64'h40, 1, 4, 6, 4'b0010, 1, 0, 0, 0, 1));
        ex_memread = 0;

        // LDUR X7,[X2,#-8]: port 2 reads bits 20:16 = 31 -> 0
        instruction_in = enc_d(C_LDUR, 9'h1F8, 2, 7);
        comb("ldur", 1, 0, 0);
        step("ldur", e_full(7, 0, 64'hFFFF_FFFF_FFFF_FFF8, 1, 64'h40, 2, 31, 7, 4'b0010, 1, 1, 0, 1, 1));

        // STUR X1,[X2,#16]: Rt is read, so a load into X1 stalls it
        instruction_in = enc_d(C_STUR, 9'd16, 2, 1);
        ex_memread = 1; ex_rd = 1;
        comb("stur_rt_loaduse", 0, 0, 0);
        step("stur_bubble", e_bubble());
        ex_memread = 0;
        comb("stur", 1, 0, 0);
        step("stur", e_full(7, 5, 64'd16, 1, 64'h40, 2, 1, 1, 4'b0010, 1, 0, 1, 0, 0));

        instruction_in = enc_r(C_SUB, 1, 2, 8);
        step("sub", e_full(7, 5, 0, 0, 64'h40, 2, 1, 8, 4'b0110, 0, 0, 0, 0, 1));
        instruction_in = enc_r(C_AND, 2, 1, 9);
        step("and", e_full(5, 7, 0, 0, 64'h40, 1, 2, 9, 4'b0000, 0, 0, 0, 0, 1));
        instruction_in = enc_r(C_ORR, 2, 1, 10);
        step("orr", e_full(5, 7, 0, 0, 64'h40, 1, 2, 10, 4'b0001, 0, 0, 0, 0, 1));

        // CBZ X5,+3 at pc_inc 0x104 -> target 0x10C
        instruction_in = '0; wb_regwrite = 1; wb_rd = 5; wb_data = 0;
        step("wb_x5_zero", e_bubble());
        wb_regwrite = 0;
        pc_inc_in = 64'h104; instruction_in = enc_cbz(19'd3, 5);
        comb("cbz_taken", 1, 1, 1);
        brt("cbz_taken", 64'h10C);
        step("cbz_taken_bubble", e_bubble());
        ex_regwrite = 1; ex_rd = 5;
        comb("cbz_ex_stall", 0, 0, 0);
        step("cbz_ex_stall_bubble", e_bubble());
        ex_regwrite = 0; mem_regwrite = 1; mem_rd = 5;
        comb("cbz_mem_stall", 0, 0, 0);
        step("cbz_mem_stall_bubble", e_bubble());
        mem_rd = 6;
        comb("cbz_mem_other", 1, 1, 1);
        step("cbz_mem_other_bubble", e_bubble());
        mem_regwrite = 0;
        instruction_in = enc_cbz(19'd3, 31); ex_regwrite = 1; ex_rd = 31;
        comb("cbz_xzr_no_stall", 1, 1, 1);
        step("cbz_xzr_bubble", e_bubble());
        ex_regwrite = 0;
        instruction_in = '0; wb_regwrite = 1; wb_rd = 5; wb_data = 64'd9;
        step("wb_x5_nine", e_bubble());
        wb_regwrite = 0;
        instruction_in = enc_cbz(19'd3, 5);
        comb("cbz_not_taken", 1, 0, 0);
        brt("cbz_not_taken", 64'h10C);
        step("cbz_not_taken", e_full(0, 9, 0, 0, 64'h104, 3, 5, 5, 4'b0000, 0, 0, 0, 0, 0));

        // B -2 at 0x10 -> 0x4; B 0 at 0 -> wraps
        pc_inc_in = 64'h10; instruction_in = enc_b(26'h3FFFFFE);
        comb("b_back", 1, 1, 1);
        brt("b_back", 64'h4);
        step("b_back_bubble", e_bubble());
        pc_inc_in = 64'h0; instruction_in = enc_b(26'h0);
        comb("b_wrap", 1, 1, 1);
        brt("b_wrap", 64'hFFFF_FFFF_FFFF_FFFC);
        step("b_wrap_bubble", e_bubble());

        // XZR: write attempt and same-cycle read both yield 0
        pc_inc_in = 64'h40;
        wb_regwrite = 1; wb_rd = 31; wb_data = 64'hFF;
        instruction_in = enc_r(C_ADD, 31, 31, 10);
        comb("xzr_write", 1, 0, 0);
        step("xzr_same_cycle", e_full(0, 0, 0, 0, 64'h40, 31, 31, 10, 4'b0010, 0, 0, 0, 0, 1));
        wb_regwrite = 0; ex_memread = 1; ex_rd = 31;
        comb("xzr_loaduse", 1, 0, 0);
        step("xzr_read", e_full(0, 0, 0, 0, 64'h40, 31, 31, 10, 4'b0010, 0, 0, 0, 0, 1));
        ex_memread = 0;

        // Write-through of X4 while reading it, then read back stored value
        wb_regwrite = 1; wb_rd = 4; wb_data = 64'hAB;
        instruction_in = enc_r(C_ADD, 1, 4, 11);
        step("write_through_x4", e_full(64'hAB, 5, 0, 0, 64'h40, 4, 1, 11, 4'b0010, 0, 0, 0, 0, 1));
        wb_regwrite = 0;
        instruction_in = enc_r(C_ADD, 4, 4, 12);
        step("x4_stored", e_full(64'hAB, 64'hAB, 0, 0, 64'h40, 4, 4, 12, 4'b0010, 0, 0, 0, 0, 1));

        // Reset during a CBZ stall
        pc_inc_in = 64'h104; instruction_in = enc_cbz(19'd3, 5);
        ex_regwrite = 1; ex_rd = 5;
        comb("pre_reset_stall", 0, 0, 0);
        step("pre_reset_stall_bubble", e_bubble());
        reset = 1;
        comb("reset_in_stall", 1, 0, 0);
        step("reset_in_stall", e_zero());
        reset = 0; ex_regwrite = 0;
        comb("cbz_after_reset", 1, 1, 1);
        brt("cbz_after_reset", 64'h10C);
        step("cbz_after_reset_bubble", e_bubble());
        pc_inc_in = 64'h40; instruction_in = enc_r(C_ADD, 2, 1, 3);
        comb("add_after_reset", 1, 0, 0);
        step("add_cleared_regs", e_full(0, 0, 0, 0, 64'h40, 1, 2, 3, 4'b0010, 0, 0, 0, 0, 1));
        instruction_in = '0;
        step("final_bubble", e_bubble());

        @(negedge clock);
        @(negedge clock);
        cmp("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
